// File: rtl/boxhead_hpi_pkg.sv
// Shared types for the OTG HPI bridge: FSM state encoding, HPI register
// indices and the latched request record.
package boxhead_hpi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        ACK     = 3'd4,
        RECOVER = 3'd5
    } hpi_state_t;

    // HPI register map as seen on avs_address / otg_addr
    localparam logic [1:0] HPI_REG_DATA    = 2'd0;
    localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_REG_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

    // Request captured in IDLE; the Avalon side is ignored until the next IDLE
    typedef struct packed {
        logic        dir_wr;
        logic [1:0]  addr;
        logic [15:0] wdata;
    } hpi_req_t;

endpackage

// File: rtl/boxhead_hpi_phase_timer.sv
// Loadable down-counter that times one FSM phase. Loading N-1 makes 'done'
// pulse in the N-th clock after the load; it stays quiet until reloaded.
module boxhead_hpi_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;
    logic             armed;

    // Count down from the loaded value; disarm once zero has been reported
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= load_val;
            armed <= 1'b1;
        end else if (armed) begin
            if (cnt == '0)
                armed <= 1'b0;
            else
                cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = armed && (cnt == '0);

endmodule

// File: rtl/boxhead_soc_otg_hpi_bridge.sv
// Avalon-MM slave that runs a full CY7C67200 HPI bus cycle per access with
// programmable setup/strobe/hold/recovery timing, stalling the master with
// waitrequest until the cycle completes.
// Optional build macro: HPI_IRQ_SYNC_EN -- when defined, otg_int is brought
// into the clock domain through two flops and drives irq; otherwise irq is 0.
module boxhead_soc_otg_hpi_bridge
    import boxhead_hpi_pkg::*;
#(
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 4,
    parameter int HOLD_CYCLES     = 1,
    parameter int RECOVERY_CYCLES = 2,
    parameter int CNT_W           = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_chipselect,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [1:0]  otg_addr,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in,
    input  logic        otg_int,
    output logic        irq
);

    // Timer reload values: a phase of N clocks loads N-1
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LD    = CNT_W'((RECOVERY_CYCLES > 0) ? RECOVERY_CYCLES - 1 : 0);

    hpi_state_t       state, state_nxt;
    hpi_req_t         req_q, req_nxt;
    logic             req;
    logic             active;
    logic             cs_n_q, rd_n_q, wr_n_q, oe_q;
    logic             cs_n_nxt, rd_n_nxt, wr_n_nxt, oe_nxt;
    logic [15:0]      rdata_q, rdata_nxt;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             phase_done;

    // A write wins when read and write are raised together
    assign req             = avs_chipselect & (avs_read | avs_write);
    assign avs_waitrequest = req & (state != ACK);

    boxhead_hpi_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (phase_done)
    );

    // State and registered pin values; reset drops every pin to idle at once
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            req_q   <= '0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_nxt;
            req_q   <= req_nxt;
            cs_n_q  <= cs_n_nxt;
            rd_n_q  <= rd_n_nxt;
            wr_n_q  <= wr_n_nxt;
            oe_q    <= oe_nxt;
            rdata_q <= rdata_nxt;
        end
    end

    // Phase sequencing; the timer is reloaded on entry to every timed phase
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            IDLE: if (req) begin
                state_nxt = SETUP;
                tmr_load  = 1'b1;
                tmr_val   = SETUP_LD;
            end
            SETUP: if (phase_done) begin
                state_nxt = STROBE;
                tmr_load  = 1'b1;
                tmr_val   = STROBE_LD;
            end
            STROBE: if (phase_done) begin
                state_nxt = HOLD;
                tmr_load  = 1'b1;
                tmr_val   = HOLD_LD;
            end
            HOLD: if (phase_done) state_nxt = ACK;
            ACK: begin
                if (RECOVERY_CYCLES == 0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RECOVER;
                    tmr_load  = 1'b1;
                    tmr_val   = REC_LD;
                end
            end
            RECOVER: if (phase_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next pin values follow the state being entered, so pins change with the state
    always_comb begin
        req_nxt = req_q;
        if (state == IDLE && req) begin
            req_nxt.dir_wr = avs_write;
            req_nxt.addr   = avs_address;
            if (avs_write)
                req_nxt.wdata = avs_writedata;
        end
        active   = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);
        cs_n_nxt = ~active;
        oe_nxt   = active & req_nxt.dir_wr;
        rd_n_nxt = ~((state_nxt == STROBE) & ~req_nxt.dir_wr);
        wr_n_nxt = ~((state_nxt == STROBE) &  req_nxt.dir_wr);
        // Sample the pad on the clock that ends the read strobe
        rdata_nxt = rdata_q;
        if (state == STROBE && phase_done && !req_q.dir_wr)
            rdata_nxt = otg_data_in;
    end

    assign otg_addr     = req_q.addr;
    assign otg_data_out = req_q.wdata;
    assign otg_cs_n     = cs_n_q;
    assign otg_rd_n     = rd_n_q;
    assign otg_wr_n     = wr_n_q;
    assign otg_data_oe  = oe_q;
    assign avs_readdata = rdata_q;

`ifdef HPI_IRQ_SYNC_EN
    logic [1:0] irq_sync;

    // Two-flop synchronizer for the asynchronous chip interrupt
    always_ff @(posedge clk) begin
        if (reset)
            irq_sync <= '0;
        else
            irq_sync <= {irq_sync[0], otg_int};
    end

    assign irq = irq_sync[1];
`else
    // Interrupt not routed; software polls the STATUS register instead
    logic unused_otg_int;
    assign unused_otg_int = otg_int;
    assign irq            = 1'b0;
`endif

endmodule
